pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage register enables and flushes, and the PC enable.
- Sequences the multi-cycle multiplier in EX: pulses its start, holds the front end for the multiplier latency, then steers the result into EX/MEM.
- Also handles load-use stalls and taken branch/jump flushes resolved in MEM.

Parameters:
- MUL_LAT, 2, multiplier latency in cycles from start to valid product; legal range 2..15.
- CNT_W, 4, width of the latency counter; must satisfy 2^CNT_W > MUL_LAT.

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset; synchronous, active-low (sampled on rising clk edge only)
- enable  in  1  global run; 0 freezes the pipeline and this FSM
- id_instr  in  32  instruction in the IF/ID register
- ex_instr  in  32  instruction in the ID/EX register
- ex_mem_read  in  1  mem_read control bit in ID/EX
- mem_take  in  1  branch taken (branch & zero) or jump, in EX/MEM
- pc_en  out  1  PC update enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load zero (bubble) into that register when its enable is also high
- mult_start  out  1  one-cycle start pulse to the multiplier
- ex_result_sel  out  1  EX/MEM result mux select: 0 = ALU, 1 = multiplier product
- busy  out  1  high while in MUL_WAIT

Behaviour:
- **Outputs:** all outputs are combinational from the state, the counter and the inputs.
- **Reset:** while arst_n=0 at a clk edge, state<=RUN and cnt<=0. With enable=0, every output is 0.
- **Multiply decode:** ex_is_mul = ex_instr[6:0]==7'b0110011 && [31:25]==7'b0000001 && [14:12]==3'b000. Bubbles (all zero) never decode as mul.
- **Load-use decode:** ld_use = ex_mem_read && rd!=0 && (rd==id_instr[19:15] || rd==id_instr[24:20]), where rd=ex_instr[11:7]. Both source fields are always compared; a conservative stall is acceptable.
- **enable=0:** all enables, flushes and mult_start are 0; state and cnt hold.
- **State RUN, enable=1.** Priority is evaluated top-down:
  1. mem_take: pc_en=1. All four register enables =1. if_id_flush=id_ex_flush=ex_mem_flush=1. No mult_start; any mul in EX is killed. Stay in RUN.
  2. ex_is_mul: mult_start=1. pc_en=if_id_en=id_ex_en=0. ex_mem_en=1 and ex_mem_flush=1 (bubble downstream); mem_wb_en=1. cnt<=MUL_LAT-2. Go to MUL_WAIT.
  3. ld_use: pc_en=if_id_en=0. id_ex_en=1 and id_ex_flush=1. ex_mem_en=mem_wb_en=1. Stay in RUN.
  4. Otherwise: all enables =1, no flushes, ex_result_sel=0.
- **State MUL_WAIT, enable=1:** busy=1. Load-use detection is suppressed. mem_take is ignored; it cannot be legally asserted here because EX/MEM holds bubbles.
  - cnt!=0: same stall pattern as entry (front end held, EX/MEM bubble); cnt<=cnt-1.
  - cnt==0: ex_result_sel=1; all enables =1; no flushes; go to RUN. The mul retires into EX/MEM and the next instruction enters EX.
- **Latency:** a mul occupies EX for exactly MUL_LAT enabled cycles. The product is captured into EX/MEM on the last of them.
- **Back-to-back muls:** the second mul re-triggers from RUN on the cycle after completion.
- **Reset mid-operation:** returns to RUN immediately. The multiplier is not re-started; the pipeline registers are cleared by their own reset.
- **enable dropping in MUL_WAIT:** state and cnt freeze. Resumption continues the count; the external multiplier is required to hold its output.

Decomposition:
- Shared Verilog include (cpu_defines.vh) holds:
  - opcode constants OPC_RTYPE=7'b0110011 and OPC_LOAD=7'b0000011
  - FUNCT7_MULDIV=7'b0000001 and FUNCT3_MUL=3'b000
  - state encodings ST_RUN=1'b0 and ST_MUL_WAIT=1'b1
- One natural sub-module: load_use_detect, the combinational ld_use compare. The FSM/counter stays in pipe_hazard_ctrl.

Test Plan:
- **Reset:** arst_n=0 for 2 clk with enable=1, then release. Require state RUN, busy=0, mult_start=0, and all enables =1 with no flush once ex_instr=0.
- **Single mul, MUL_LAT=2:** ex_instr=0x02B50533 (mul a0,a0,a1).
  - Cycle 0: mult_start=1, pc_en=0, ex_mem_flush=1.
  - Cycle 1: busy=1, ex_result_sel=1, all enables =1.
  - Cycle 2: RUN.
- **MUL_LAT=4, enable gap:** mul in EX, then enable=0 for 3 cycles during MUL_WAIT. Require ex_result_sel=1 exactly 3 enabled wait-cycles after start, with outputs all 0 while enable=0.
- **Load-use:** ex lw x5 (ex_mem_read=1, rd=5) with id add x6,x5,x7. Require pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle. Then with ex_instr=0, no stall.
- **Load to x0:** same pattern but rd=0 → no stall.
- **Flush beats mul:** mem_take=1 while ex_is_mul=1. Require all three flushes =1, mult_start=0, state stays RUN.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared definitions for the 5-stage pipeline hazard controller:
//   RV32 opcode/funct constants, the controller state encoding, the bundle of
//   per-stage control outputs, and the canonical control patterns the FSM
//   selects between.
// -----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    // RV32 encoding fields used by the hazard decode.
    localparam logic [6:0] OPC_RTYPE     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;

    // Controller state. RUN is the normal flow; MUL_WAIT holds the front end
    // while the multi-cycle multiplier in EX completes.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

    // Every control output of the block, kept together so each scheduling
    // decision can be written as one pattern assignment.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mult_start;
        logic ex_result_sel;
        logic busy;
    } ctrl_t;

    // Frozen pipeline: nothing moves, nothing is flushed.
    localparam ctrl_t CTRL_NONE = '0;

    // Normal flow: every stage advances, no bubbles.
    localparam ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
        ex_mem_flush: 1'b0, mult_start: 1'b0, ex_result_sel: 1'b0,
        busy: 1'b0
    };

    // Taken branch/jump resolved in MEM: fetch the target and squash the
    // three younger instructions in IF/ID, ID/EX and EX/MEM.
    localparam ctrl_t CTRL_FLUSH_ALL = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1,
        ex_mem_flush: 1'b1, mult_start: 1'b0, ex_result_sel: 1'b0,
        busy: 1'b0
    };

    // Multiplier occupying EX: PC, IF/ID and ID/EX hold; a bubble is pushed
    // into EX/MEM so older instructions can still drain through MEM/WB.
    localparam ctrl_t CTRL_MUL_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
        ex_mem_flush: 1'b1, mult_start: 1'b0, ex_result_sel: 1'b0,
        busy: 1'b0
    };

    // Load-use hazard: hold PC and IF/ID, insert a bubble into ID/EX so the
    // load advances one stage ahead of its consumer.
    localparam ctrl_t CTRL_LD_STALL = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b1,
        ex_mem_flush: 1'b0, mult_start: 1'b0, ex_result_sel: 1'b0,
        busy: 1'b0
    };

    // True for the RV32M MUL instruction only (not MULH*, DIV*, REM*).
    // An all-zero bubble has opcode 0 and can never match.
    function automatic logic is_mul(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7);
        return (opcode == OPC_RTYPE) && (funct7 == FUNCT7_MULDIV) &&
               (funct3 == FUNCT3_MUL);
    endfunction

endpackage : pipe_hazard_ctrl_pkg

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_load_use_detect
//   Combinational load-use hazard detector. Flags when the load in ID/EX
//   writes a register that the instruction in IF/ID reads.
//
//   Ports:
//     id_instr_i     [31:0]  instruction in IF/ID (the potential consumer)
//     ex_instr_i     [31:0]  instruction in ID/EX (the potential load)
//     ex_mem_read_i          mem_read control bit of the ID/EX instruction
//     ld_use_o               hazard present, stall one cycle
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl_load_use_detect (
    input  logic [31:0] id_instr_i,
    input  logic [31:0] ex_instr_i,
    input  logic        ex_mem_read_i,
    output logic        ld_use_o
);

    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;

    assign ex_rd  = ex_instr_i[11:7];
    assign id_rs1 = id_instr_i[19:15];
    assign id_rs2 = id_instr_i[24:20];

    // Both source fields are compared regardless of the consumer's format
    // (I-type and U-type have no real rs2). The occasional needless stall is
    // cheaper than decoding the format here. x0 is never a real dependency.
    assign ld_use_o = ex_mem_read_i && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Fields of the two instructions that play no part in the compare.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:0],
                                 ex_instr_i[31:12], ex_instr_i[6:0]};

endmodule : pipe_hazard_ctrl_load_use_detect

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Decides, every enabled cycle, which pipeline registers load, which load a
//   bubble, and whether the PC advances. Sequences the multi-cycle multiplier
//   in EX: pulses its start, holds the front end for MUL_LAT cycles, and then
//   steers the product into EX/MEM.
//
//   Decision priority in RUN: taken branch/jump in MEM, then mul in EX, then
//   load-use, then normal flow. In MUL_WAIT only the countdown matters.
//
//   Parameters:
//     MUL_LAT  multiplier latency, start to valid product (2..15)
//     CNT_W    latency counter width, 2**CNT_W > MUL_LAT
//
//   Ports:
//     clk            clock
//     arst_n         synchronous active-low reset (sampled on rising clk)
//     enable         global run; 0 freezes the pipeline and this controller
//     id_instr       instruction in IF/ID
//     ex_instr       instruction in ID/EX
//     ex_mem_read    mem_read control bit in ID/EX
//     mem_take       taken branch or jump in EX/MEM
//     pc_en          PC update enable
//     *_en           pipeline register enables
//     *_flush        load a bubble into that register (with its enable)
//     mult_start     one-cycle start pulse to the multiplier
//     ex_result_sel  EX/MEM result mux: 0 = ALU, 1 = multiplier product
//     busy           multiplier wait in progress
//
//   All outputs are combinational from state, counter and inputs.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    input  logic [31:0] id_instr,
    input  logic [31:0] ex_instr,
    input  logic        ex_mem_read,
    input  logic        mem_take,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        mult_start,
    output logic        ex_result_sel,
    output logic        busy
);

    // The start cycle is the first of MUL_LAT cycles and the cnt==0 wait
    // cycle is the last, so the countdown starts at MUL_LAT-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    ctrl_t            ctrl;
    logic             ex_is_mul;
    logic             ld_use;

    // ------------------------------------------------------------------
    // Hazard decode
    // ------------------------------------------------------------------
    assign ex_is_mul = is_mul(ex_instr[6:0], ex_instr[14:12], ex_instr[31:25]);

    pipe_hazard_ctrl_load_use_detect u_load_use_detect (
        .id_instr_i    (id_instr),
        .ex_instr_i    (ex_instr),
        .ex_mem_read_i (ex_mem_read),
        .ld_use_o      (ld_use)
    );

    // ------------------------------------------------------------------
    // Scheduling decision and next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        ctrl    = CTRL_NONE;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (enable) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_take) begin
                        // Squash wins even over a mul in EX: that mul is on
                        // the wrong path and must never start.
                        ctrl = CTRL_FLUSH_ALL;
                    end else if (ex_is_mul) begin
                        ctrl            = CTRL_MUL_STALL;
                        ctrl.mult_start = 1'b1;
                        cnt_d           = CNT_LOAD;
                        state_d         = ST_MUL_WAIT;
                    end else if (ld_use) begin
                        ctrl = CTRL_LD_STALL;
                    end else begin
                        ctrl = CTRL_ADVANCE;
                    end
                end

                ST_MUL_WAIT: begin
                    // Load-use is not checked here: the consumer in IF/ID is
                    // held anyway. mem_take cannot occur since EX/MEM only
                    // carries bubbles while the mul is in EX.
                    if (cnt_q != '0) begin
                        ctrl  = CTRL_MUL_STALL;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        // Last multiplier cycle: the product retires into
                        // EX/MEM and the next instruction enters EX.
                        ctrl               = CTRL_ADVANCE;
                        ctrl.ex_result_sel = 1'b1;
                        state_d            = ST_RUN;
                    end
                    ctrl.busy = 1'b1;
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: reset is synchronous, so arst_n is tested inside the clocked
    // block and does not appear in the sensitivity list; sequential state
    // uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign id_ex_en      = ctrl.id_ex_en;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_flush  = ctrl.ex_mem_flush;
    assign mult_start    = ctrl.mult_start;
    assign ex_result_sel = ctrl.ex_result_sel;
    assign busy          = ctrl.busy;

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Drives two controllers (MUL_LAT=2 and MUL_LAT=4) with identical inputs.
//   A driver applies one cycle of stimulus per falling edge and pushes the
//   reference model's expected outputs into queues; a monitor pops and
//   compares them shortly after each falling edge.
//   Output vector order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//   if_id_flush, id_ex_flush, ex_mem_flush, mult_start, ex_result_sel, busy}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] I_MUL  = 32'h02B5_0533; // mul  a0,a0,a1
    localparam logic [31:0] I_MULH = 32'h02B5_1533; // mulh a0,a0,a1
    localparam logic [31:0] I_DIV  = 32'h02B5_4533; // div  a0,a0,a1
    localparam logic [31:0] I_LW5  = 32'h0005_2283; // lw   x5,0(x10)
    localparam logic [31:0] I_LW0  = 32'h0005_2003; // lw   x0,0(x10)
    localparam logic [31:0] I_ADD  = 32'h0072_8333; // add  x6,x5,x7
    localparam logic [31:0] I_ADD2 = 32'h0053_8333; // add  x6,x7,x5
    localparam logic [31:0] I_ADD0 = 32'h0003_8333; // add  x6,x7,x0

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic [31:0] id_instr;
    logic [31:0] ex_instr;
    logic        ex_mem_read;
    logic        mem_take;

    logic pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2;
    logic if_id_flush2, id_ex_flush2, ex_mem_flush2, mult_start2, sel2, busy2;
    logic pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
    logic if_id_flush4, id_ex_flush4, ex_mem_flush4, mult_start4, sel4, busy4;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .id_instr(id_instr), .ex_instr(ex_instr),
        .ex_mem_read(ex_mem_read), .mem_take(mem_take),
        .pc_en(pc_en2), .if_id_en(if_id_en2), .id_ex_en(id_ex_en2),
        .ex_mem_en(ex_mem_en2), .mem_wb_en(mem_wb_en2),
        .if_id_flush(if_id_flush2), .id_ex_flush(id_ex_flush2),
        .ex_mem_flush(ex_mem_flush2), .mult_start(mult_start2),
        .ex_result_sel(sel2), .busy(busy2)
    );

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .arst_n(arst_n), .enable(enable),
        .id_instr(id_instr), .ex_instr(ex_instr),
        .ex_mem_read(ex_mem_read), .mem_take(mem_take),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
        .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .ex_mem_flush(ex_mem_flush4), .mult_start(mult_start4),
        .ex_result_sel(sel4), .busy(busy4)
    );

    logic [10:0] got2, got4;
    assign got2 = {pc_en2, if_id_en2, id_ex_en2, ex_mem_en2, mem_wb_en2,
                   if_id_flush2, id_ex_flush2, ex_mem_flush2, mult_start2,
                   sel2, busy2};
    assign got4 = {pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4,
                   if_id_flush4, id_ex_flush4, ex_mem_flush4, mult_start4,
                   sel4, busy4};

    int checks = 0;
    int errors = 0;

    logic [10:0] exp2_q[$];
    logic [10:0] exp4_q[$];
    string       name_q[$];

    // Reference state: how many enabled cycles the current mul has already
    // spent in EX (0 = no mul in progress).
    int age2 = 0;
    int age4 = 0;

    task automatic check(input string name, input logic [10:0] got,
                         input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    // Behavioural reference: what the scheduler must do this cycle given a
    // mul that has already spent age_in enabled cycles in EX.
    task automatic model(input int lat, input int age_in,
                         output logic [10:0] o, output int age_out);
        logic pc, ifid, idex, exmem, memwb, fif, fidex, fexmem, st, sel, bsy;
        logic is_mul, lduse;
        {pc, ifid, idex, exmem, memwb, fif, fidex, fexmem, st, sel, bsy} = '0;
        age_out = age_in;
        is_mul = (ex_instr[6:0] == 7'h33) && (ex_instr[31:25] == 7'h01) &&
                 (ex_instr[14:12] == 3'd0);
        lduse  = ex_mem_read && (ex_instr[11:7] != 5'd0) &&
                 (ex_instr[11:7] == id_instr[19:15] ||
                  ex_instr[11:7] == id_instr[24:20]);
        if (enable) begin
            if (age_in > 0) begin
                bsy = 1'b1;
                if (age_in + 1 == lat) begin
                    {pc, ifid, idex, exmem, memwb} = '1;
                    sel     = 1'b1;
                    age_out = 0;
                end else begin
                    {exmem, fexmem, memwb} = '1;
                    age_out = age_in + 1;
                end
            end else if (mem_take) begin
                {pc, ifid, idex, exmem, memwb, fif, fidex, fexmem} = '1;
            end else if (is_mul) begin
                {st, exmem, fexmem, memwb} = '1;
                age_out = 1;
            end else if (lduse) begin
                {idex, fidex, exmem, memwb} = '1;
            end else begin
                {pc, ifid, idex, exmem, memwb} = '1;
            end
        end
        o = {pc, ifid, idex, exmem, memwb, fif, fidex, fexmem, st, sel, bsy};
    endtask

    // One cycle of stimulus. Expectations are queued only for cycles out of
    // reset; a reset cycle clears the reference state.
    task automatic drive(input string name, input logic rst_n, input logic en,
                         input logic [31:0] ex, input logic [31:0] id,
                         input logic mr, input logic tk);
        logic [10:0] e2, e4;
        int n2, n4;
        @(negedge clk);
        arst_n      = rst_n;
        enable      = en;
        ex_instr    = ex;
        id_instr    = id;
        ex_mem_read = mr;
        mem_take    = tk;
        if (!rst_n) begin
            age2 = 0;
            age4 = 0;
        end else begin
            model(2, age2, e2, n2);
            model(4, age4, e4, n4);
            age2 = n2;
            age4 = n4;
            exp2_q.push_back(e2);
            exp4_q.push_back(e4);
            name_q.push_back(name);
        end
    endtask

    // Monitor: compares each queued expectation against the outputs while
    // the inputs of that cycle are stable.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (name_q.size() > 0) begin
                string n;
                n = name_q.pop_front();
                check({n, " lat2"}, got2, exp2_q.pop_front());
                check({n, " lat4"}, got4, exp4_q.pop_front());
            end
        end
    end

    initial begin
        arst_n = 1'b0; enable = 1'b1; id_instr = '0; ex_instr = '0;
        ex_mem_read = 1'b0; mem_take = 1'b0;

        // Reset, then normal flow with a bubble in EX.
        drive("rst", 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        drive("rst", 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
        drive("post_rst", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
        drive("disabled", 1'b1, 1'b0, I_MUL, I_ADD, 1'b0, 1'b0);

        // Single mul held in ID/EX until retired (lat4 needs 4 cycles;
        // lat2 retires and then sees the held mul as a new one).
        for (int i = 0; i < 4; i++) drive("mul_single", 1'b1, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        drive("after_mul", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
        drive("after_mul", 1'b1, 1'b1, I_MULH, '0, 1'b0, 1'b0);
        drive("after_mul", 1'b1, 1'b1, I_DIV, '0, 1'b0, 1'b0);

        // Enable gap inside MUL_WAIT.
        drive("gap_start", 1'b1, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        drive("gap_wait", 1'b1, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive("gap_off", 1'b1, 1'b0, I_MUL, '0, 1'b0, 1'b1);
        drive("gap_resume", 1'b1, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        drive("gap_resume", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive("gap_drain", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);

        // Load-use on rs1 and rs2, then no stall once the load has moved on.
        drive("lduse_rs1", 1'b1, 1'b1, I_LW5, I_ADD, 1'b1, 1'b0);
        drive("lduse_gone", 1'b1, 1'b1, '0, I_ADD, 1'b0, 1'b0);
        drive("lduse_rs2", 1'b1, 1'b1, I_LW5, I_ADD2, 1'b1, 1'b0);
        drive("lduse_nomr", 1'b1, 1'b1, I_LW5, I_ADD, 1'b0, 1'b0);
        drive("lduse_x0", 1'b1, 1'b1, I_LW0, I_ADD0, 1'b1, 1'b0);

        // Taken branch beats a mul in EX; next cycle must still be RUN.
        drive("take_vs_mul", 1'b1, 1'b1, I_MUL, I_ADD, 1'b1, 1'b1);
        drive("take_after", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);

        // Reset in the middle of a multiply.
        drive("rst_mid", 1'b1, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        drive("rst_mid", 1'b0, 1'b1, I_MUL, '0, 1'b0, 1'b0);
        drive("rst_after", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ex, id;
            logic [31:0] pick;
            logic mr;
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: ex = I_MUL;
                3:       ex = I_MULH;
                4, 5:    ex = {20'($urandom), 5'($urandom_range(0, 7)), 7'h03};
                6:       ex = '0;
                default: ex = $urandom;
            endcase
            id = $urandom;
            if ($urandom_range(0, 1) == 0) id[19:15] = ex[11:7];
            if ($urandom_range(0, 3) == 0) id[24:20] = ex[11:7];
            mr = (ex[6:0] == 7'h03) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
            drive("random",
                  1'($urandom_range(0, 49) != 0),
                  1'($urandom_range(0, 4) != 0),
                  ex, id, mr,
                  1'($urandom_range(0, 7) == 0));
        end

        drive("final", 1'b1, 1'b1, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #4;
        checks++;
        if (name_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", name_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
